// File: rtl/bch_encode_serial.sv
// bch_encode_serial
// Bit-serial systematic BCH encoder. Message bits pass straight through
// (MSB first) while an LFSR divides by g(x); the P-bit remainder follows
// as parity, MSB first. Ready/valid on both sides.
// Optional feature macro: BCH_ENC_ABORT_EN adds a synchronous 'abort' input
// that discards the codeword in flight.
module bch_encode_serial #(
  parameter int            M   = 4,
  parameter int            K   = 5,
  parameter int            P   = 10,
  parameter logic [P-1:0]  GEN = 10'h137
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_data,
  input  logic in_valid,
  output logic in_ready,
  output logic out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic parity_phase
`ifdef BCH_ENC_ABORT_EN
  ,
  input  logic abort
`endif
);

  localparam int KP   = (K > P) ? K : P;
  localparam int CW   = (KP > 1) ? $clog2(KP) : 1;
  localparam int NMAX = (1 << M) - 1;
  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] PM1 = CW'(P - 1);

  // Codeword must fit in the field; parity needs at least two bits.
  if ((K + P) > NMAX || K < 1 || P < 2) begin : g_bad_params
    $error("bch_encode_serial: illegal K/P/M combination");
  end

  typedef enum logic {S_DATA = 1'b0, S_PARITY = 1'b1} phase_t;

  phase_t          r_phase;
  logic [P-1:0]    r_lfsr;
  logic [CW-1:0]   r_cnt;

  logic            w_abort;
  logic            w_in_data_phase;
  logic            w_beat;
  logic            w_fb;
  logic [P-1:0]    w_lfsr_nxt;

`ifdef BCH_ENC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_in_data_phase = (r_phase == S_DATA);

  // Handshake view: data phase is a wire from input to output; parity phase
  // is self-sourced. Reset and abort both silence the handshake.
  assign in_ready     = rst_n & ~w_abort & w_in_data_phase & out_ready;
  assign out_valid    = rst_n & ~w_abort & (w_in_data_phase ? in_valid : 1'b1);
  assign out_data     = w_in_data_phase ? in_data : r_lfsr[P-1];
  assign parity_phase = ~w_in_data_phase;
  assign out_last     = ~w_in_data_phase & (r_cnt == PM1);
  assign w_beat       = out_valid & out_ready;

  // Feedback only while dividing the message; parity phase just shifts out.
  assign w_fb = w_in_data_phase & (in_data ^ r_lfsr[P-1]);

  // One LFSR stage per bit: shift up, fold in the generator tap on feedback.
  for (genvar b = 0; b < P; b++) begin : g_lfsr
    if (b == 0) begin : g_lsb
      assign w_lfsr_nxt[b] = w_fb & GEN[b];
    end else begin : g_upper
      assign w_lfsr_nxt[b] = r_lfsr[b-1] ^ (w_fb & GEN[b]);
    end
  end

  // Phase/count/LFSR state; abort outranks a coincident beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= S_DATA;
      r_lfsr  <= '0;
      r_cnt   <= '0;
    end else if (w_abort) begin
      r_phase <= S_DATA;
      r_lfsr  <= '0;
      r_cnt   <= '0;
    end else if (w_beat) begin
      case (r_phase)
        S_DATA: begin
          r_lfsr <= w_lfsr_nxt;
          if (r_cnt == KM1) begin
            r_cnt   <= '0;
            r_phase <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == PM1) begin
            r_cnt   <= '0;
            r_phase <= S_DATA;
            r_lfsr  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_lfsr <= w_lfsr_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encode_serial.sv
// Scoreboard bench for bch_encode_serial: the stimulus side queues the
// expected codeword (computed by polynomial long division), a free-running
// monitor pops and compares on every output beat.
module tb_bch_encode_serial;

  localparam int           K   = 5;
  localparam int           P   = 10;
  localparam int           N   = K + P;
  localparam logic [P-1:0] GEN = 10'h137;

  logic clk = 1'b0;
  logic rst_n, in_data, in_valid, in_ready, out_data, out_valid, out_ready;
  logic out_last, parity_phase;
  logic abort;

  always #5 clk = ~clk;

  bch_encode_serial #(.M(4), .K(K), .P(P), .GEN(GEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .parity_phase(parity_phase)
`ifdef BCH_ENC_ABORT_EN
    , .abort(abort)
`endif
  );

  typedef struct {logic d; logic l; logic p;} exp_t;
  exp_t exp_q[$];
  logic [N-1:0] cw_log[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_beats = 0, cw_cnt = 0;
  int mark_beats = -1, mark_cyc = 0, last_beat_cyc = 0;
  logic [N-1:0] cap = '0, last_cw = '0;
  logic stall_mode = 1'b0;
  logic prev_stall = 1'b0, prev_data = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Remainder of a codeword-length polynomial modulo g(x), by long division.
  function automatic logic [P-1:0] rem_of(input logic [N-1:0] cw);
    logic [N-1:0] r;
    logic [P:0]   g;
    r = cw;
    g = {1'b1, GEN};
    for (int i = N - 1; i >= P; i--)
      if (r[i]) r[i -: P+1] = r[i -: P+1] ^ g;
    return r[P-1:0];
  endfunction

  function automatic logic [N-1:0] codeword(input logic [K-1:0] msg);
    return {msg, rem_of({msg, {P{1'b0}}})};
  endfunction

  // Monitor: compare every beat against the queue, watch hold-under-stall.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {63'd0, out_data}, {63'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (n_beats == mark_beats) mark_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", {63'd0, out_data}, {63'd0, e.d});
          chk("out_last", {63'd0, out_last}, {63'd0, e.l});
          chk("parity_phase", {63'd0, parity_phase}, {63'd0, e.p});
        end
        cap = {cap[N-2:0], out_data};
        n_beats++;
        last_beat_cyc = cyc;
        if (out_last) begin
          last_cw = cap;
          cw_log.push_back(cap);
          cw_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Sink backpressure: random in stall mode, otherwise always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic wait_fire(input string name);
    int t;
    logic fired;
    t = 0;
    fired = 1'b0;
    while (!fired && t < 300) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!fired) chk({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  // Drive nbits of msg (MSB first) and queue the first npush codeword bits.
  task automatic send(input logic [K-1:0] msg, input int nbits, input int npush);
    logic [N-1:0] cw;
    cw = codeword(msg);
    for (int i = 0; i < npush; i++) begin
      exp_t e;
      e.d = cw[N-1-i];
      e.l = (i == N - 1);
      e.p = (i >= K);
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbits; i++) begin
      if (stall_mode) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data  = msg[K-1-i];
      wait_fire("in_beat");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_cw(input int target);
    int t;
    t = 0;
    while (cw_cnt < target && t < 2000) begin @(posedge clk); t++; end
    if (cw_cnt < target) chk("codeword_timeout", 64'd1, 64'd0);
    #1;
  endtask

  logic [P-1:0] pa, pb, pc;
  logic [K-1:0] msgs[8];
  logic [N-1:0] run_a[8];
  int base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 1'b1; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_parity_phase", {63'd0, parity_phase}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // g(x) itself is the codeword of message 1.
    base = cw_cnt;
    send(5'b00001, K, N);
    wait_cw(base + 1);
    chk("cw_00001", {49'd0, last_cw}, {49'd0, 5'b00001, 10'b0100110111});

    base = cw_cnt;
    send(5'b00000, K, N);
    wait_cw(base + 1);
    chk("cw_zero", {49'd0, last_cw}, 64'd0);

    // Linearity and zero syndromes on the DUT's own output.
    base = cw_cnt;
    send(5'b10000, K, N); wait_cw(base + 1);
    pa = last_cw[P-1:0];
    chk("syn_10000", {54'd0, rem_of(last_cw)}, 64'd0);
    send(5'b00001, K, N); wait_cw(base + 2);
    pb = last_cw[P-1:0];
    send(5'b10001, K, N); wait_cw(base + 3);
    pc = last_cw[P-1:0];
    chk("syn_10001", {54'd0, rem_of(last_cw)}, 64'd0);
    chk("linearity", {54'd0, pc}, {54'd0, pa ^ pb});

    // Random messages with stalls, then the same without, back to back.
    for (int i = 0; i < 8; i++) msgs[i] = K'($urandom);
    stall_mode = 1'b1;
    base = cw_cnt;
    for (int i = 0; i < 8; i++) send(msgs[i], K, N);
    wait_cw(base + 8);
    for (int i = 0; i < 8; i++) run_a[i] = cw_log[base + i];
    stall_mode = 1'b0;
    repeat (3) @(posedge clk); #1;
    mark_beats = n_beats;
    base = cw_cnt;
    for (int i = 0; i < 8; i++) send(msgs[i], K, N);
    wait_cw(base + 8);
    mark_beats = -1;
    chk("no_dead_cycles", 64'(last_beat_cyc - mark_cyc), 64'(8 * N - 1));
    for (int i = 0; i < 8; i++)
      chk("stall_vs_nostall", {49'd0, cw_log[base + i]}, {49'd0, run_a[i]});

    // Reset after three data beats discards the partial codeword.
    send(5'b10110, 3, 3);
    rst_n = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    base = cw_cnt;
    send(5'b00001, K, N);
    wait_cw(base + 1);
    chk("cw_after_rst", {49'd0, last_cw}, {49'd0, 5'b00001, 10'b0100110111});

`ifdef BCH_ENC_ABORT_EN
    // Abort at parity count 4 with the sink ready: no beat that cycle.
    send(5'b10110, K, K + 4);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    base = cw_cnt;
    send(5'b01101, K, N);
    wait_cw(base + 1);
    chk("cw_after_abort", {49'd0, last_cw}, {49'd0, codeword(5'b01101)});
`endif

    repeat (5) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
